fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_fetch_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// =============================================================================
// Module   : fetch_unit
// Purpose  : Single-outstanding instruction fetch FSM with a one-group hold
//            register; optional perf counters under FETCH_PERF_CNT_EN.
// Revision : 1.0 - initial release
// =============================================================================
module fetch_unit #(
   parameter int unsigned INST_FETCH_NUM  = 4,
   parameter int unsigned INST_INDEX_SIZE = 32,
   parameter logic [31:0] RESET_PC        = 32'h8000_0000
) (
   input  logic                                      clock,
   input  logic                                      reset,
   output logic                                      icache_req_valid,
   input  logic                                      icache_req_ready,
   output logic [31:0]                               icache_req_addr,
   input  logic                                      icache_resp_valid,
   input  logic [INST_FETCH_NUM*INST_INDEX_SIZE-1:0] icache_resp_data,
   input  logic                                      buffer_full,
   input  logic                                      redirect_valid,
   input  logic [31:0]                               redirect_pc,
   output logic [INST_FETCH_NUM*INST_INDEX_SIZE-1:0] inst_value,
   output logic [INST_FETCH_NUM-1:0]                 inst_valid,
   output logic [31:0]                               fetch_pc,
   output logic [31:0]                               perf_group_cnt,
   output logic [31:0]                               perf_stall_cnt
);

   localparam int unsigned GROUP_W = INST_FETCH_NUM * INST_INDEX_SIZE;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } state_t;

   state_t                    state_q;
   logic [31:0]               pc_q;
   logic [31:0]               hold_pc_q;
   logic [GROUP_W-1:0]        hold_data_q;
   logic                      req_valid_q;
   logic [31:0]               req_addr_q;
   logic [GROUP_W-1:0]        inst_value_q;
   logic [INST_FETCH_NUM-1:0] inst_valid_q;
   logic [31:0]               fetch_pc_q;

   logic                      deliver_d;
   logic [31:0]               dlv_pc_d;
   logic [GROUP_W-1:0]        dlv_data_d;
   logic [INST_FETCH_NUM-1:0] dlv_mask_d;
   logic [31:0]               dlv_next_pc_d;

   // A group is delivered straight from the response or from the hold register.
   always_comb begin
      deliver_d     = !redirect_valid && !buffer_full &&
                      (((state_q == S_WAIT) && icache_resp_valid) || (state_q == S_HOLD));
      dlv_pc_d      = (state_q == S_HOLD) ? hold_pc_q : pc_q;
      dlv_data_d    = (state_q == S_HOLD) ? hold_data_q : icache_resp_data;
      dlv_next_pc_d = {dlv_pc_d[31:4], 4'b0000} + 32'd16;
      dlv_mask_d    = '0;
      for (int unsigned i = 0; i < INST_FETCH_NUM; i++) begin
         dlv_mask_d[i] = (i >= {30'd0, dlv_pc_d[3:2]});
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         hold_pc_q    <= '0;
         hold_data_q  <= '0;
         req_valid_q  <= 1'b0;
         req_addr_q   <= '0;
         inst_value_q <= '0;
         inst_valid_q <= '0;
         fetch_pc_q   <= '0;
      end else begin
         inst_valid_q <= '0;
         if (redirect_valid) begin
            pc_q        <= redirect_pc;
            req_valid_q <= 1'b0;
            hold_data_q <= '0;
            hold_pc_q   <= '0;
            case (state_q)
               S_REQ:   state_q <= (req_valid_q && icache_req_ready) ? S_DROP : S_REQ;
               S_HOLD:  state_q <= S_REQ;
               default: state_q <= icache_resp_valid ? S_REQ : S_DROP;
            endcase
         end else begin
            case (state_q)
               S_REQ: begin
                  if (!req_valid_q) begin
                     req_valid_q <= 1'b1;
                     req_addr_q  <= {pc_q[31:4], 4'b0000};
                  end else if (icache_req_ready) begin
                     req_valid_q <= 1'b0;
                     state_q     <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (icache_resp_valid) begin
                     hold_data_q <= icache_resp_data;
                     hold_pc_q   <= pc_q;
                     state_q     <= buffer_full ? S_HOLD : S_REQ;
                  end
               end
               S_HOLD: begin
                  if (!buffer_full) begin
                     state_q <= S_REQ;
                  end
               end
               default: begin
                  if (icache_resp_valid) begin
                     state_q <= S_REQ;
                  end
               end
            endcase
            if (deliver_d) begin
               inst_valid_q <= dlv_mask_d;
               inst_value_q <= dlv_data_d;
               fetch_pc_q   <= dlv_pc_d;
               pc_q         <= dlv_next_pc_d;
            end
         end
      end
   end

   assign icache_req_valid = req_valid_q;
   assign icache_req_addr  = req_addr_q;
   assign inst_value       = inst_value_q;
   assign inst_valid       = inst_valid_q;
   assign fetch_pc         = fetch_pc_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_group_q;
   logic [31:0] perf_stall_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         perf_group_q <= '0;
         perf_stall_q <= '0;
      end else begin
         if (deliver_d) begin
            perf_group_q <= perf_group_q + 32'd1;
         end
         if (state_q == S_HOLD) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_group_cnt = perf_group_q;
   assign perf_stall_cnt = perf_stall_q;
`else
   assign perf_group_cnt = '0;
   assign perf_stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// =============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed and randomized checks of fetch_unit against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_fetch_unit;

   localparam int unsigned NF = 4;
   localparam int unsigned GW = NF * 32;

   logic          clock;
   logic          reset;
   logic          icache_req_valid;
   logic          icache_req_ready;
   logic [31:0]   icache_req_addr;
   logic          icache_resp_valid;
   logic [GW-1:0] icache_resp_data;
   logic          buffer_full;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic [GW-1:0] inst_value;
   logic [NF-1:0] inst_valid;
   logic [31:0]   fetch_pc;
   logic [31:0]   perf_group_cnt;
   logic [31:0]   perf_stall_cnt;

   fetch_unit #(
      .INST_FETCH_NUM  (NF),
      .INST_INDEX_SIZE (32),
      .RESET_PC        (32'h8000_0000)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .icache_req_valid  (icache_req_valid),
      .icache_req_ready  (icache_req_ready),
      .icache_req_addr   (icache_req_addr),
      .icache_resp_valid (icache_resp_valid),
      .icache_resp_data  (icache_resp_data),
      .buffer_full       (buffer_full),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .inst_value        (inst_value),
      .inst_valid        (inst_valid),
      .fetch_pc          (fetch_pc),
      .perf_group_cnt    (perf_group_cnt),
      .perf_stall_cnt    (perf_stall_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: architectural pc, redirect epoch, one in-flight
   // cache access and whether an accepted group is waiting for delivery.
   logic [31:0]   exp_pc = 32'h8000_0000;
   int            epoch = 0;
   bit            held = 0;
   bit            infl_v = 0;
   logic [31:0]   infl_addr = '0;
   int            infl_tag = 0;
   int            infl_cnt = 0;
   int            lat = 2;
   bit            rnd_lat = 0;
   logic [NF-1:0] exp_mask = '0;
   logic [GW-1:0] exp_val = '0;
   logic [31:0]   exp_fpc = '0;
   logic [31:0]   exp_groups = '0;
   logic [31:0]   exp_stalls = '0;
   bit            req_hold_prev = 0;

   bit            hs_now = 0;
   bit            dlv_now = 0;
   bit            obs_req = 0;
   int            dlv_cnt = 0;
   logic [31:0]   last_hs_addr = '0;
   logic [NF-1:0] last_mask = '0;
   logic [31:0]   last_fpc = '0;
   logic [GW-1:0] last_val = '0;

   function automatic logic [GW-1:0] gdata(input logic [31:0] a);
      logic [GW-1:0] d;
      d = '0;
      for (int i = 0; i < NF; i++) d[32*i +: 32] = (a + 32'(4 * i)) ^ 32'h5A3C_0F00;
      return d;
   endfunction

   task automatic check(input string tag, input logic [GW-1:0] obs, input logic [GW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check registered outputs, play the cache, advance the model.
   task automatic step(input bit rdy, input bit bf, input bit rv, input logic [31:0] rpc);
      bit            rsp;
      bit            hs;
      bit            held_start;
      int            rtag;
      int            new_tag;
      logic [GW-1:0] rdata;
      logic [NF-1:0] m;
      @(negedge clock);
      check("inst_valid", {{(GW-NF){1'b0}}, inst_valid}, {{(GW-NF){1'b0}}, exp_mask});
      dlv_now = (inst_valid != '0);
      hs_now  = 1'b0;
      if (exp_mask != '0) begin
         check("fetch_pc", {{(GW-32){1'b0}}, fetch_pc}, {{(GW-32){1'b0}}, exp_fpc});
         check("inst_value", inst_value, exp_val);
      end
      if (dlv_now) begin
         dlv_cnt++;
         last_mask = inst_valid;
         last_fpc  = fetch_pc;
         last_val  = inst_value;
      end
      if (infl_v || held) check("req_idle", {{(GW-1){1'b0}}, icache_req_valid}, '0);
      if (req_hold_prev) check("req_stable", {{(GW-1){1'b0}}, icache_req_valid}, 1);
      if (icache_req_valid)
         check("req_addr", {{(GW-32){1'b0}}, icache_req_addr}, {{(GW-32){1'b0}}, exp_pc[31:4], 4'h0});
      obs_req = icache_req_valid;
`ifdef FETCH_PERF_CNT_EN
      check("perf_group", {{(GW-32){1'b0}}, perf_group_cnt}, {{(GW-32){1'b0}}, exp_groups});
      check("perf_stall", {{(GW-32){1'b0}}, perf_stall_cnt}, {{(GW-32){1'b0}}, exp_stalls});
`else
      check("perf_tied", {{(GW-64){1'b0}}, perf_group_cnt, perf_stall_cnt}, '0);
`endif
      rsp   = 1'b0;
      rtag  = 0;
      rdata = gdata($urandom);
      if (infl_v) begin
         if (infl_cnt <= 1) begin
            rsp    = 1'b1;
            rtag   = infl_tag;
            rdata  = gdata(infl_addr);
            infl_v = 1'b0;
         end else begin
            infl_cnt--;
         end
      end
      hs         = icache_req_valid && rdy;
      held_start = held;
      new_tag    = epoch;
      if (hs) begin
         hs_now       = 1'b1;
         last_hs_addr = icache_req_addr;
      end
      if (rv) begin
         epoch++;
         exp_pc = rpc;
         held   = 1'b0;
      end
      if (rsp && rtag == epoch) held = 1'b1;
      if (hs) begin
         infl_v    = 1'b1;
         infl_addr = icache_req_addr;
         infl_tag  = new_tag;
         infl_cnt  = rnd_lat ? int'($urandom_range(1, 3)) : lat;
      end
      if (held && !bf && !rv) begin
         m          = {NF{1'b1}};
         exp_mask   = m << exp_pc[3:2];
         exp_val    = gdata({exp_pc[31:4], 4'h0});
         exp_fpc    = exp_pc;
         exp_pc     = {exp_pc[31:4], 4'h0} + 32'd16;
         held       = 1'b0;
         exp_groups = exp_groups + 32'd1;
      end else begin
         exp_mask = '0;
      end
      if (held_start) exp_stalls = exp_stalls + 32'd1;
      req_hold_prev     = icache_req_valid && !rdy && !rv;
      icache_req_ready  = rdy;
      buffer_full       = bf;
      redirect_valid    = rv;
      redirect_pc       = rpc;
      icache_resp_valid = rsp;
      icache_resp_data  = rdata;
   endtask

   task automatic wait_hs(input string tag);
      int k;
      k = 0;
      do begin
         step(1'b1, 1'b0, 1'b0, 32'h0);
         k++;
      end while (!hs_now && k < 40);
      check(tag, {{(GW-1){1'b0}}, hs_now}, 1);
   endtask

   task automatic wait_dlv(input string tag);
      int k;
      k = 0;
      do begin
         step(1'b1, 1'b0, 1'b0, 32'h0);
         k++;
      end while (!dlv_now && k < 40);
      check(tag, {{(GW-1){1'b0}}, dlv_now}, 1);
   endtask

   initial begin
      int          d0;
      logic [31:0] stall0;
      reset             = 1'b0;
      icache_req_ready  = 1'b0;
      icache_resp_valid = 1'b0;
      icache_resp_data  = '0;
      buffer_full       = 1'b0;
      redirect_valid    = 1'b0;
      redirect_pc       = '0;
      repeat (3) @(negedge clock);
      check("rst_inst_valid", {{(GW-NF){1'b0}}, inst_valid}, '0);
      check("rst_inst_value", inst_value, '0);
      check("rst_fetch_pc", {{(GW-32){1'b0}}, fetch_pc}, '0);
      check("rst_req_valid", {{(GW-1){1'b0}}, icache_req_valid}, '0);
      reset = 1'b1;

      // Reset release: first request, full group, sequential successor.
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check("first_req_after_reset", {{(GW-1){1'b0}}, obs_req}, 1);
      wait_hs("t1_hs_timeout");
      check("t1_addr", {{(GW-32){1'b0}}, last_hs_addr}, {{(GW-32){1'b0}}, 32'h8000_0000});
      wait_dlv("t1_dlv_timeout");
      check("t1_mask", {{(GW-NF){1'b0}}, last_mask}, {{(GW-NF){1'b0}}, 4'b1111});
      check("t1_value", last_val, gdata(32'h8000_0000));
      wait_hs("t1_next_timeout");
      check("t1_next_addr", {{(GW-32){1'b0}}, last_hs_addr}, {{(GW-32){1'b0}}, 32'h8000_0010});

      // Unaligned redirect target.
      step(1'b0, 1'b0, 1'b1, 32'h0000_100C);
      wait_dlv("t2_dlv_timeout");
      check("t2_mask", {{(GW-NF){1'b0}}, last_mask}, {{(GW-NF){1'b0}}, 4'b1000});
      check("t2_fetch_pc", {{(GW-32){1'b0}}, last_fpc}, {{(GW-32){1'b0}}, 32'h0000_100C});
      wait_hs("t2_next_timeout");
      check("t2_next_addr", {{(GW-32){1'b0}}, last_hs_addr}, {{(GW-32){1'b0}}, 32'h0000_1010});

      // Back-pressure: response lands while the buffer is full for 5 cycles.
      stall0 = perf_stall_cnt;
      step(1'b0, 1'b0, 1'b0, 32'h0);
      d0 = dlv_cnt;
      repeat (5) step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check("t3_no_pulse_while_full", 32'(dlv_cnt - d0), 0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check("t3_one_pulse", 32'(dlv_cnt - d0), 1);
`ifdef FETCH_PERF_CNT_EN
      check("t3_stall_cnt", {{(GW-32){1'b0}}, perf_stall_cnt - stall0}, 5);
`endif

      // Redirect while waiting: stale response must vanish.
      wait_hs("t4_hs_timeout");
      d0 = dlv_cnt;
      step(1'b0, 1'b0, 1'b1, 32'h0000_2000);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      wait_hs("t4_next_timeout");
      check("t4_next_addr", {{(GW-32){1'b0}}, last_hs_addr}, {{(GW-32){1'b0}}, 32'h0000_2000});
      check("t4_dropped", 32'(dlv_cnt - d0), 0);

      // Address wrap at the top of the address space.
      step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0);
      wait_dlv("t5_dlv_timeout");
      check("t5_fetch_pc", {{(GW-32){1'b0}}, last_fpc}, {{(GW-32){1'b0}}, 32'hFFFF_FFF0});
      check("t5_mask", {{(GW-NF){1'b0}}, last_mask}, {{(GW-NF){1'b0}}, 4'b1111});
      wait_hs("t5_next_timeout");
      check("t5_next_addr", {{(GW-32){1'b0}}, last_hs_addr}, '0);

      // Randomized traffic with random latency, back-pressure and redirects.
      rnd_lat = 1'b1;
      d0 = dlv_cnt;
      for (int c = 0; c < 3000; c++) begin
         logic [31:0] rpc;
         rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1C))
                                          : ($urandom & 32'hFFFF_FFFC);
         step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
              $urandom_range(0, 99) < 4, rpc);
      end
      repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);
      check("rand_progress", {{(GW-1){1'b0}}, (dlv_cnt - d0) > 50}, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
